// File: rtl/ysyx_22040895_lsu_if.sv
// Execute-side, data-bus and writeback-side signals of the LSU, bundled with
// modports: slave is the LSU view, master is the surrounding pipeline/memory view.
interface ysyx_22040895_lsu_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid_i_lsu;
  logic              in_ready_o_lsu;
  logic [ADDR_W-1:0] addr_i_lsu;
  logic [63:0]       wdata_i_lsu;
  logic [1:0]        sl_i_lsu;
  logic [2:0]        funct3_i_lsu;
  logic              mem_req_o_lsu;
  logic              mem_we_o_lsu;
  logic [ADDR_W-1:0] mem_addr_o_lsu;
  logic [63:0]       mem_wdata_o_lsu;
  logic [7:0]        mem_wmask_o_lsu;
  logic              mem_gnt_i_lsu;
  logic              mem_rvalid_i_lsu;
  logic [63:0]       mem_rdata_i_lsu;
  logic              out_valid_o_lsu;
  logic              out_ready_i_lsu;
  logic [63:0]       result_o_lsu;
  logic [1:0]        fault_o_lsu;
  logic              busy_o_lsu;

  modport slave (
    input  in_valid_i_lsu, addr_i_lsu, wdata_i_lsu, sl_i_lsu, funct3_i_lsu,
           mem_gnt_i_lsu, mem_rvalid_i_lsu, mem_rdata_i_lsu, out_ready_i_lsu,
    output in_ready_o_lsu, mem_req_o_lsu, mem_we_o_lsu, mem_addr_o_lsu,
           mem_wdata_o_lsu, mem_wmask_o_lsu, out_valid_o_lsu, result_o_lsu,
           fault_o_lsu, busy_o_lsu
  );

  modport master (
    output in_valid_i_lsu, addr_i_lsu, wdata_i_lsu, sl_i_lsu, funct3_i_lsu,
           mem_gnt_i_lsu, mem_rvalid_i_lsu, mem_rdata_i_lsu, out_ready_i_lsu,
    input  in_ready_o_lsu, mem_req_o_lsu, mem_we_o_lsu, mem_addr_o_lsu,
           mem_wdata_o_lsu, mem_wmask_o_lsu, out_valid_o_lsu, result_o_lsu,
           fault_o_lsu, busy_o_lsu
  );
endinterface

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: one req/gnt/rvalid transaction at a time, 1-cycle pass-through, optional watchdog (YSYX_22040895_LSU_TIMEOUT_EN).
// Latency 1 cycle for non-memory ops, 1 + bus for memory ops; in_ready drops while busy or while the output entry is held.
module ysyx_22040895_lsu #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_22040895_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  localparam logic [1:0] FLT_OK  = 2'b00;
  localparam logic [1:0] FLT_MIS = 2'b01;
  localparam logic [1:0] FLT_ILL = 2'b10;
  localparam logic [1:0] FLT_TMO = 2'b11;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wmask;
  logic              r_out_vld;
  logic [63:0]       r_result;
  logic [1:0]        r_fault;

  logic        w_in_rdy;
  logic        w_accept;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_illegal;
  logic        w_misal;
  logic [2:0]  w_byte_off;
  logic [7:0]  w_base_mask;
  logic [7:0]  w_st_mask;
  logic [63:0] w_st_data;
  logic [63:0] w_ld_shift;
  logic [63:0] w_ld_ext;
  logic        w_tmo;
  logic        w_latch;
  logic        w_out_load;
  logic [63:0] w_out_result;
  logic [1:0]  w_out_fault;

  // Memory ops are only accepted with the output entry free (or draining now),
  // so their completion can always load it without a stall.
  assign w_in_rdy   = rst_n & (r_state == IDLE) & (~r_out_vld | bus.out_ready_i_lsu);
  assign w_accept   = bus.in_valid_i_lsu & w_in_rdy;
  assign w_is_ld    = (bus.sl_i_lsu == 2'b01);
  assign w_is_st    = (bus.sl_i_lsu == 2'b10);
  assign w_illegal  = (w_is_ld & (bus.funct3_i_lsu == 3'b111)) | (w_is_st & bus.funct3_i_lsu[2]);
  assign w_byte_off = bus.addr_i_lsu[2:0];
  assign w_st_mask  = w_base_mask << w_byte_off;
  assign w_st_data  = bus.wdata_i_lsu << {w_byte_off, 3'b000};
  assign w_ld_shift = bus.mem_rdata_i_lsu >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_misal     = 1'b0;
    w_base_mask = 8'h01;
    case (bus.funct3_i_lsu[1:0])
      2'b00: begin w_misal = 1'b0;                    w_base_mask = 8'h01; end
      2'b01: begin w_misal = w_byte_off[0];           w_base_mask = 8'h03; end
      2'b10: begin w_misal = |w_byte_off[1:0];        w_base_mask = 8'h0F; end
      default: begin w_misal = |w_byte_off;           w_base_mask = 8'hFF; end
    endcase
  end

  always_comb begin
    w_ld_ext = '0;
    case (r_funct3)
      3'b000:  w_ld_ext = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
      3'b001:  w_ld_ext = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b010:  w_ld_ext = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
      3'b011:  w_ld_ext = w_ld_shift;
      3'b100:  w_ld_ext = {56'd0, w_ld_shift[7:0]};
      3'b101:  w_ld_ext = {48'd0, w_ld_shift[15:0]};
      3'b110:  w_ld_ext = {32'd0, w_ld_shift[31:0]};
      default: w_ld_ext = '0;
    endcase
  end

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_latch) begin
      r_tmo_cnt <= '0;
    end else if (r_state != IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_out_load   = 1'b0;
    w_out_result = '0;
    w_out_fault  = FLT_OK;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_out_load = 1'b1;
          if (!w_is_ld && !w_is_st) begin
            w_out_result = 64'(bus.addr_i_lsu);
          end else if (w_illegal) begin
            w_out_fault = FLT_ILL;
          end else if (w_misal) begin
            w_out_fault = FLT_MIS;
          end else begin
            w_out_load  = 1'b0;
            w_latch     = 1'b1;
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt_i_lsu && r_we) begin
          w_out_load  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tmo) begin
          w_out_load  = 1'b1;
          w_out_fault = FLT_TMO;
          w_state_nxt = IDLE;
        end else if (bus.mem_gnt_i_lsu) begin
          w_state_nxt = WAIT_R;
        end
      end
      WAIT_R: begin
        if (bus.mem_rvalid_i_lsu) begin
          w_out_load   = 1'b1;
          w_out_result = w_ld_ext;
          w_state_nxt  = IDLE;
        end else if (w_tmo) begin
          w_out_load  = 1'b1;
          w_out_fault = FLT_TMO;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wmask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr   <= bus.addr_i_lsu;
        r_funct3 <= bus.funct3_i_lsu;
        r_we     <= w_is_st;
        r_wdata  <= w_is_st ? w_st_data : 64'd0;
        r_wmask  <= w_is_st ? w_st_mask : 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_result  <= '0;
      r_fault   <= FLT_OK;
    end else if (w_out_load) begin
      r_out_vld <= 1'b1;
      r_result  <= w_out_result;
      r_fault   <= w_out_fault;
    end else if (bus.out_ready_i_lsu) begin
      r_out_vld <= 1'b0;
      r_result  <= '0;
      r_fault   <= FLT_OK;
    end
  end

  assign bus.in_ready_o_lsu  = w_in_rdy;
  assign bus.mem_req_o_lsu   = (r_state == REQ);
  assign bus.mem_we_o_lsu    = r_we;
  assign bus.mem_addr_o_lsu  = {r_addr[ADDR_W-1:3], 3'b000};
  assign bus.mem_wdata_o_lsu = r_wdata;
  assign bus.mem_wmask_o_lsu = r_wmask;
  assign bus.out_valid_o_lsu = r_out_vld;
  assign bus.result_o_lsu    = r_result;
  assign bus.fault_o_lsu     = r_fault;
  assign bus.busy_o_lsu      = (r_state != IDLE);

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed and randomized bench for ysyx_22040895_lsu with a byte-level memory reference model.
// Define YSYX_22040895_LSU_TIMEOUT_EN to also exercise the watchdog with a 16-cycle limit.
module tb_ysyx_22040895_lsu;

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22040895_lsu_if #(.ADDR_W(64)) bus ();

  ysyx_22040895_lsu #(.ADDR_W(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  bit          auto_mode = 1'b0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [63:0] m_rdata = '0;
  logic        a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [63:0] a_rdata = '0;
  logic [63:0] bus_mem [8];
  logic [7:0]  ref_mem [64];
  int          gnt_cnt  = 0;
  int          addr_err = 0;

  assign bus.mem_gnt_i_lsu    = auto_mode ? a_gnt    : m_gnt;
  assign bus.mem_rvalid_i_lsu = auto_mode ? a_rvalid : m_rvalid;
  assign bus.mem_rdata_i_lsu  = auto_mode ? a_rdata  : m_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op and returns one cycle after it was accepted.
  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sl,
                       input logic [2:0] f3);
    int n;
    n = 0;
    while (!bus.in_ready_o_lsu && n < 100) begin
      step();
      n++;
    end
    chk("issue_ready", {63'd0, bus.in_ready_o_lsu}, 64'd1);
    bus.in_valid_i_lsu = 1'b1;
    bus.addr_i_lsu     = a;
    bus.wdata_i_lsu    = wd;
    bus.sl_i_lsu       = sl;
    bus.funct3_i_lsu   = f3;
    step();
    bus.in_valid_i_lsu = 1'b0;
  endtask

  task automatic wait_out(input int lim, output int n);
    n = 0;
    while (!bus.out_valid_o_lsu && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic man_load(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] rd,
                          input logic [63:0] exp, input string tag);
    issue(a, 64'd0, 2'b01, f3);
    chk({tag, "_req"}, {63'd0, bus.mem_req_o_lsu}, 64'd1);
    chk({tag, "_we"}, {63'd0, bus.mem_we_o_lsu}, 64'd0);
    chk({tag, "_addr"}, bus.mem_addr_o_lsu, a & ~64'd7);
    m_gnt = 1'b1;
    step();
    m_gnt = 1'b0;
    chk({tag, "_req_off"}, {63'd0, bus.mem_req_o_lsu}, 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.busy_o_lsu}, 64'd1);
    m_rvalid = 1'b1;
    m_rdata  = rd;
    step();
    m_rvalid = 1'b0;
    chk({tag, "_valid"}, {63'd0, bus.out_valid_o_lsu}, 64'd1);
    chk({tag, "_result"}, bus.result_o_lsu, exp);
    chk({tag, "_fault"}, {62'd0, bus.fault_o_lsu}, 64'd0);
    step();
  endtask

  // Memory responder for the random phase: grants within a few cycles, returns read data 1-3 cycles later.
  initial begin : responder
    logic        cap_we;
    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_mask;
    bit          rd_pend;
    int          rd_dly, rd_idx, req_wait;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_mask = '0;
    rd_pend = 1'b0; rd_dly = 0; rd_idx = 0; req_wait = 0;
    forever begin
      @(negedge clk);
      if (!auto_mode || !rst_n) begin
        a_gnt = 1'b0; a_rvalid = 1'b0; rd_pend = 1'b0; req_wait = 0;
      end else begin
        a_rvalid = 1'b0;
        if (a_gnt) begin
          a_gnt = 1'b0;
          req_wait = 0;
          gnt_cnt++;
          if (cap_addr[63:6] != 58'h200_0000 || cap_addr[2:0] != 3'd0) addr_err++;
          if (cap_we) begin
            for (int b = 0; b < 8; b++)
              if (cap_mask[b]) bus_mem[cap_addr[5:3]][8*b +: 8] = cap_wdata[8*b +: 8];
          end else begin
            rd_pend = 1'b1;
            rd_dly  = $urandom_range(1, 3);
            rd_idx  = int'(cap_addr[5:3]);
          end
        end else if (bus.mem_req_o_lsu) begin
          if ($urandom_range(0, 2) == 0 || req_wait >= 4) begin
            a_gnt     = 1'b1;
            cap_we    = bus.mem_we_o_lsu;
            cap_addr  = bus.mem_addr_o_lsu;
            cap_wdata = bus.mem_wdata_o_lsu;
            cap_mask  = bus.mem_wmask_o_lsu;
          end
          req_wait++;
        end
        if (rd_pend) begin
          if (rd_dly == 1) begin
            a_rvalid = 1'b1;
            a_rdata  = bus_mem[rd_idx];
            rd_pend  = 1'b0;
          end else begin
            rd_dly--;
          end
        end
      end
    end
  end

  initial begin : main
    logic [63:0] q_src[$];
    logic [63:0] got[$];
    int          n;

    rst_n = 1'b0;
    bus.in_valid_i_lsu  = 1'b0;
    bus.addr_i_lsu      = '0;
    bus.wdata_i_lsu     = '0;
    bus.sl_i_lsu        = 2'b00;
    bus.funct3_i_lsu    = 3'b000;
    bus.out_ready_i_lsu = 1'b1;
    #3;
    chk("rst_mem_req", {63'd0, bus.mem_req_o_lsu}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid_o_lsu}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy_o_lsu}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready_o_lsu}, 64'd0);
    chk("rst_result", bus.result_o_lsu, 64'd0);
    chk("rst_fault", {62'd0, bus.fault_o_lsu}, 64'd0);
    chk("rst_wmask", {56'd0, bus.mem_wmask_o_lsu}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Byte loads from lane 3 of 0x1122_3344_8877_6655 (lane byte 0x88).
    man_load(64'h8000_0003, 3'b000, 64'h1122_3344_8877_6655, 64'hFFFF_FFFF_FFFF_FF88, "lb");
    man_load(64'h8000_0003, 3'b100, 64'h1122_3344_8877_6655, 64'h0000_0000_0000_0088, "lbu");

    // Halfword store to lane 6 with the grant held back 3 cycles.
    issue(64'h8000_0006, 64'h0000_0000_0000_ABCD, 2'b10, 3'b001);
    for (int c = 0; c < 4; c++) begin
      chk("sh_req", {63'd0, bus.mem_req_o_lsu}, 64'd1);
      chk("sh_we", {63'd0, bus.mem_we_o_lsu}, 64'd1);
      chk("sh_addr", bus.mem_addr_o_lsu, 64'h8000_0000);
      chk("sh_wmask", {56'd0, bus.mem_wmask_o_lsu}, 64'hC0);
      chk("sh_wdata", bus.mem_wdata_o_lsu, 64'hABCD_0000_0000_0000);
      chk("sh_no_out", {63'd0, bus.out_valid_o_lsu}, 64'd0);
      if (c == 3) m_gnt = 1'b1;
      step();
    end
    m_gnt = 1'b0;
    chk("sh_valid", {63'd0, bus.out_valid_o_lsu}, 64'd1);
    chk("sh_req_off", {63'd0, bus.mem_req_o_lsu}, 64'd0);
    chk("sh_result", bus.result_o_lsu, 64'd0);
    chk("sh_fault", {62'd0, bus.fault_o_lsu}, 64'd0);
    step();

    // Misaligned word load never reaches the bus.
    issue(64'h8000_0002, 64'd0, 2'b01, 3'b010);
    chk("lw_mis_req", {63'd0, bus.mem_req_o_lsu}, 64'd0);
    chk("lw_mis_valid", {63'd0, bus.out_valid_o_lsu}, 64'd1);
    chk("lw_mis_fault", {62'd0, bus.fault_o_lsu}, 64'd1);
    chk("lw_mis_result", bus.result_o_lsu, 64'd0);
    step();

    // Pass-through stream 1,2,3 with the writeback side stalled for two cycles.
    q_src = '{64'd1, 64'd2, 64'd3};
    got.delete();
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      bus.out_ready_i_lsu = (c >= 3);
      bus.in_valid_i_lsu  = (q_src.size() > 0);
      bus.sl_i_lsu        = 2'b00;
      bus.addr_i_lsu      = (q_src.size() > 0) ? q_src[0] : 64'd0;
      #4;
      if (bus.out_valid_o_lsu)
        chk("stream_in_ready", {63'd0, bus.in_ready_o_lsu}, {63'd0, bus.out_ready_i_lsu});
      if (bus.in_valid_i_lsu && bus.in_ready_o_lsu) void'(q_src.pop_front());
      if (bus.out_valid_o_lsu && bus.out_ready_i_lsu) got.push_back(bus.result_o_lsu);
      step();
    end
    bus.in_valid_i_lsu  = 1'b0;
    bus.out_ready_i_lsu = 1'b1;
    chk("stream_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < got.size(); i++) chk("stream_order", got[i], 64'(i + 1));
    step();

    // Reset while waiting for read data; the late rvalid must be dropped.
    issue(64'h8000_0010, 64'd0, 2'b01, 3'b011);
    m_gnt = 1'b1;
    step();
    m_gnt = 1'b0;
    chk("rstw_busy_before", {63'd0, bus.busy_o_lsu}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_mem_req", {63'd0, bus.mem_req_o_lsu}, 64'd0);
    chk("rstw_out_valid", {63'd0, bus.out_valid_o_lsu}, 64'd0);
    chk("rstw_busy", {63'd0, bus.busy_o_lsu}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    m_rvalid = 1'b1;
    m_rdata  = 64'hDEAD_BEEF_0000_1111;
    step();
    m_rvalid = 1'b0;
    chk("rstw_late_rvalid", {63'd0, bus.out_valid_o_lsu}, 64'd0);
    chk("rstw_idle", {63'd0, bus.busy_o_lsu}, 64'd0);
    man_load(64'h8000_0008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "ld_after_rst");

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
    issue(64'h8000_0020, 64'd0, 2'b01, 3'b011);
    wait_out(40, n);
    chk("tmo_valid", {63'd0, bus.out_valid_o_lsu}, 64'd1);
    chk("tmo_cycles", 64'(n), 64'd16);
    chk("tmo_fault", {62'd0, bus.fault_o_lsu}, 64'd3);
    chk("tmo_result", bus.result_o_lsu, 64'd0);
    chk("tmo_req_off", {63'd0, bus.mem_req_o_lsu}, 64'd0);
    step();
`endif

    // Random ops against a byte-array model of a 64-byte region at 0x8000_0000.
    for (int w = 0; w < 8; w++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      bus_mem[w] = v;
      for (int b = 0; b < 8; b++) ref_mem[8*w + b] = v[8*b +: 8];
    end
    auto_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  sl;
      logic [2:0]  f3;
      logic [63:0] a, wd, exp_res, val;
      logic [1:0]  exp_flt;
      int          nb, off, kind, exp_bus, g0;
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom_range(0, 7));
      wd   = {$urandom, $urandom};
      nb   = 1 << f3[1:0];
      if (kind < 2) begin
        sl = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        a  = {$urandom, $urandom};
      end else begin
        sl = (kind < 6) ? 2'b01 : 2'b10;
        a  = 64'h8000_0000 + 64'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      end
      off     = int'(a[5:0]);
      exp_res = 64'd0;
      exp_flt = 2'b00;
      exp_bus = 0;
      if (sl == 2'b00 || sl == 2'b11) begin
        exp_res = a;
      end else if ((sl == 2'b01 && f3 == 3'b111) || (sl == 2'b10 && f3[2])) begin
        exp_flt = 2'b10;
      end else if ((int'(a[2:0]) % nb) != 0) begin
        exp_flt = 2'b01;
      end else if (sl == 2'b01) begin
        val = 64'd0;
        for (int k = 0; k < nb; k++) val = val | (64'(ref_mem[off + k]) << (8 * k));
        if (!f3[2] && nb < 8 && val[8*nb - 1]) val = val | (~64'd0 << (8 * nb));
        exp_res = val;
        exp_bus = 1;
      end else begin
        for (int k = 0; k < nb; k++) ref_mem[off + k] = wd[8*k +: 8];
        exp_bus = 1;
      end
      g0 = gnt_cnt;
      issue(a, wd, sl, f3);
      wait_out(60, n);
      chk("rnd_valid", {63'd0, bus.out_valid_o_lsu}, 64'd1);
      chk("rnd_result", bus.result_o_lsu, exp_res);
      chk("rnd_fault", {62'd0, bus.fault_o_lsu}, {62'd0, exp_flt});
      step();
      chk("rnd_bus_txn", 64'(gnt_cnt - g0), 64'(exp_bus));
    end
    auto_mode = 1'b0;
    chk("bus_addr_range", 64'(addr_err), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_lsu.md
Name: ysyx_22040895_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Consumes the execute result (effective address or ALU result), the store data and the load/store select. Performs one data-memory transaction at a time over a req/gnt/rvalid bus.
- Delivers a sign- or zero-extended writeback value to the writeback stage through a single-entry valid/ready output register.
- Non-memory ops pass through with one cycle of latency.

Parameters:
- ADDR_W, 64, address width; mem_addr_o is 8-byte aligned.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid_i_lsu  in  1  execute-stage op valid
- in_ready_o_lsu  out  1  LSU can accept an op
- addr_i_lsu  in  64  execute result: effective address for load/store, writeback value otherwise
- wdata_i_lsu  in  64  store data (rs2)
- sl_i_lsu  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- funct3_i_lsu  in  3  RISC-V size/sign field
- mem_req_o_lsu  out  1  bus request
- mem_we_o_lsu  out  1  1 = write
- mem_addr_o_lsu  out  64  {addr[63:3], 3'b000}
- mem_wdata_o_lsu  out  64  lane-shifted store data
- mem_wmask_o_lsu  out  8  byte-enable mask
- mem_gnt_i_lsu  in  1  request accepted
- mem_rvalid_i_lsu  in  1  read data valid
- mem_rdata_i_lsu  in  64  read data
- out_valid_o_lsu  out  1  writeback entry valid
- out_ready_i_lsu  in  1  writeback consumes the entry
- result_o_lsu  out  64  writeback value
- fault_o_lsu  out  2  00 ok, 01 misaligned, 10 illegal size, 11 timeout
- busy_o_lsu  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE. All outputs are 0 immediately, including mem_req, out_valid and busy.
  - An in-flight transaction is abandoned. An rvalid arriving later is ignored.
- States: IDLE, REQ, WAIT_R.
- in_ready = (state == IDLE) & (!out_valid | out_ready).
- An op is accepted when in_valid & in_ready.
- IDLE, on accept:
  - sl = 00/11: result = addr_i, fault = 00, out_valid = 1 next cycle; stay in IDLE.
  - Load, funct3 = 111: illegal size, fault 10, result 0, out_valid next cycle; no bus access.
  - Store, funct3[2] = 1: illegal size, fault 10, result 0, out_valid next cycle; no bus access.
  - Misaligned (half: addr[0] != 0; word: addr[1:0] != 0; double: addr[2:0] != 0): fault 01, result 0, out_valid next cycle; no bus access.
  - Otherwise: latch addr, funct3 and the lane-shifted data/mask, then go to REQ.
- Store encoding:
  - wmask = {sb: 8'h01, sh: 8'h03, sw: 8'h0F, sd: 8'hFF} << addr[2:0].
  - wdata = wdata_i << (8 * addr[2:0]).
- REQ:
  - mem_req = 1; we, addr, wdata and wmask are held stable until gnt.
  - Store with gnt: completes; result = 0, fault = 00, out_valid next cycle, go to IDLE.
  - Load with gnt: go to WAIT_R.
- WAIT_R:
  - mem_req = 0.
  - On rvalid: shifted = rdata >> (8 * addr[2:0]).
  - Extend per funct3: lb/lh/lw sign-extend from bit 7/15/31; lbu/lhu/lwu zero-extend; ld passes through.
  - result = extended value, out_valid next cycle, go to IDLE.
  - rvalid in the same cycle as gnt is illegal for the bus; the LSU samples rvalid only in WAIT_R.
- Output register:
  - Holds result/fault stable while out_valid & !out_ready.
  - Cleared on out_ready when no new entry is loaded.
  - A drain and a new pass-through load in the same cycle are allowed (back-to-back throughput of 1/cycle for non-memory ops).
- Memory-op ordering: memory ops start only when the output register is free, so a completion never finds it occupied.
- mem_rvalid/mem_gnt are ignored in IDLE.

Optional Feature:
- Macro: YSYX_22040895_LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the op completes with fault 11, result 0, mem_req dropped; go to IDLE.
  - A later rvalid for it is ignored.
- Undefined: no counter; the LSU waits indefinitely; fault 11 is never produced.

Test Plan:
- lb and lbu at addr 0x8000_0003, rdata 0x1122_3344_8877_6655 -> mem_addr 0x8000_0000; result 0xFFFF_FFFF_FFFF_FF88 (lb) and 0x0000_0000_0000_0088 (lbu); fault 00.
- sh addr 0x8000_0006, wdata 0xABCD, gnt delayed 3 cycles -> mem_req held for 4 cycles with we=1, wmask 0xC0, wdata 0xABCD_0000_0000_0000 stable; out_valid the cycle after gnt.
- lw addr 0x8000_0002 -> no mem_req; out_valid next cycle with fault 01, result 0.
- Pass-through stream of 3 ops (values 1, 2, 3) with out_ready held 0 for 2 cycles -> in_ready low while the entry is full; results delivered in order 1, 2, 3 with none lost or duplicated.
- rst_n pulsed low in WAIT_R -> mem_req, out_valid and busy go to 0 asynchronously; an rvalid 2 cycles later is ignored; a following ld at 0x8000_0008 completes normally.
- With YSYX_22040895_LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a load never granted -> completion with fault 11, result 0, 16 cycles after entering REQ.
